// File: rtl/receptor_pkg.sv
// -----------------------------------------------------------------------------
// receptor_pkg
// Shared definitions for the multichannel serial servo receiver.
//   rx_state_t : encodings of the bit-level receive FSM. The encoding is
//                exported on the debug 'state' port.
//   clog2w()   : counter width helper that never returns 0.
// Optional feature macro: RX_PARITY_EN. This file has no build-dependent
// content; the PARITY encoding exists in both builds.
// -----------------------------------------------------------------------------
package receptor_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_t;

   // Width needed to count 0..n-1; at least 1 bit.
   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/receptor_byte_rx.sv
// -----------------------------------------------------------------------------
// receptor_byte_rx
// Receives one UART-framed byte: start bit, DATA_BITS data bits (LSB first),
// an optional even-parity bit and a stop bit. The line is synchronised by two
// flops before any use.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_serial     : raw serial line, idle high
//   o_byte       : assembled byte; valid while o_byte_ok is high
//   o_byte_ok    : 1-cycle pulse in the stop-sample cycle, byte good
//   o_byte_err   : 1-cycle pulse in the stop-sample cycle, bad stop/parity
//   o_state      : current FSM state (debug)
// Optional feature: RX_PARITY_EN adds an even-parity bit after the data.
// -----------------------------------------------------------------------------
module receptor_byte_rx
   import receptor_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_serial,
   output logic [DATA_BITS-1:0] o_byte,
   output logic                 o_byte_ok,
   output logic                 o_byte_err,
   output logic [STATE_W-1:0]   o_state
);

   localparam int CW = clog2w(CLKS_PER_BIT);
   localparam int BW = clog2w(DATA_BITS);
   localparam logic [CW-1:0] LP_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] LP_LAST = BW'(DATA_BITS - 1);

   logic                 r_sync1, r_sync2, r_rx_d;
   rx_state_t            r_state, w_state_nx;
   logic [CW-1:0]        r_cnt, w_cnt_nx;
   logic [BW-1:0]        r_bit, w_bit_nx;
   logic [DATA_BITS-1:0] r_shift, w_shift_nx;
   logic                 r_par_err, w_par_err_nx;
   logic                 w_full;

   assign w_full  = (r_cnt == LP_FULL);
   assign o_byte  = r_shift;
   assign o_state = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_d    <= 1'b1;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_par_err <= 1'b0;
      end else begin
         r_sync1   <= i_serial;
         r_sync2   <= r_sync1;
         r_rx_d    <= r_sync2;
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_bit     <= w_bit_nx;
         r_shift   <= w_shift_nx;
         r_par_err <= w_par_err_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt + CW'(1);
      w_bit_nx     = r_bit;
      w_shift_nx   = r_shift;
      w_par_err_nx = r_par_err;
      o_byte_ok    = 1'b0;
      o_byte_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nx     = '0;
            w_bit_nx     = '0;
            w_par_err_nx = 1'b0;
            if (r_rx_d && !r_sync2) w_state_nx = ST_START;
         end
         ST_START: begin
            // Resample mid start bit; a line already high again was a glitch.
            if (r_cnt == LP_HALF) begin
               w_cnt_nx   = '0;
               w_state_nx = r_sync2 ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_full) begin
               w_cnt_nx          = '0;
               w_shift_nx[r_bit] = r_sync2;
               if (r_bit == LP_LAST) begin
`ifdef RX_PARITY_EN
                  w_state_nx = ST_PARITY;
`else
                  w_state_nx = ST_STOP;
`endif
               end else begin
                  w_bit_nx = r_bit + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            // Even parity: data ones plus parity bit must give an even count.
            if (w_full) begin
               w_cnt_nx     = '0;
               w_par_err_nx = ^{r_shift, r_sync2};
               w_state_nx   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_full) begin
               w_cnt_nx = '0;
               if (r_sync2) begin
                  o_byte_ok  = !r_par_err;
                  o_byte_err = r_par_err;
                  w_state_nx = ST_IDLE;
               end else begin
                  o_byte_err = 1'b1;
                  w_state_nx = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            w_cnt_nx = '0;
            if (r_sync2) w_state_nx = ST_IDLE;
         end
         default: begin
            w_cnt_nx   = '0;
            w_state_nx = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/receptor_serial_multicanal.sv
// -----------------------------------------------------------------------------
// receptor_serial_multicanal
// Serial receiver for NUM_CH servo set-points. A frame is SYNC_BYTE followed
// by one byte per channel; all channel outputs change together, and only
// when a whole frame arrives without error.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   canal_serial : serial line, idle high
//   angulos      : channel k at [k*DATA_BITS +: DATA_BITS]
//   frame_valid  : 1-cycle pulse, angulos just updated
//   frame_error  : 1-cycle pulse, byte error (frame aborted if one was open)
//   ch_idx       : 0 = hunting sync, k = expecting channel k-1
//   state        : bit-level FSM state (debug)
// Optional feature: RX_PARITY_EN (even parity per byte, see receptor_byte_rx).
// -----------------------------------------------------------------------------
module receptor_serial_multicanal
   import receptor_pkg::*;
#(
   parameter int                   CLKS_PER_BIT = 10,
   parameter int                   DATA_BITS    = 8,
   parameter int                   NUM_CH       = 4,
   parameter logic [DATA_BITS-1:0] SYNC_BYTE    = 8'hFF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          canal_serial,
   output logic [NUM_CH*DATA_BITS-1:0]   angulos,
   output logic                          frame_valid,
   output logic                          frame_error,
   output logic [$clog2(NUM_CH+1)-1:0]   ch_idx,
   output logic [STATE_W-1:0]            state
);

   localparam int CHW = $clog2(NUM_CH + 1);

   logic [DATA_BITS-1:0]        w_byte;
   logic                        w_byte_ok, w_byte_err;
   logic [DATA_BITS-1:0]        r_shadow [NUM_CH];
   logic [NUM_CH*DATA_BITS-1:0] r_angulos, w_ang_nx;
   logic [CHW-1:0]              r_ch;
   logic                        r_fv, r_fe;

   receptor_byte_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .DATA_BITS    (DATA_BITS)
   ) u_byte_rx (
      .clk        (clk),
      .rst        (rst),
      .i_serial   (canal_serial),
      .o_byte     (w_byte),
      .o_byte_ok  (w_byte_ok),
      .o_byte_err (w_byte_err),
      .o_state    (state)
   );

   // The last channel byte goes straight to the outputs alongside the
   // shadows, so the update needs no extra cycle.
   always_comb begin
      w_ang_nx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_ang_nx[k*DATA_BITS +: DATA_BITS] = (k == NUM_CH - 1) ? w_byte : r_shadow[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_angulos <= '0;
         r_ch      <= '0;
         r_fv      <= 1'b0;
         r_fe      <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) r_shadow[k] <= '0;
      end else begin
         r_fv <= 1'b0;
         r_fe <= 1'b0;
         if (w_byte_err) begin
            r_fe <= 1'b1;
            r_ch <= '0;
         end else if (w_byte_ok) begin
            if (r_ch == '0) begin
               if (w_byte == SYNC_BYTE) r_ch <= CHW'(1);
            end else begin
               // Inside a frame the sync value is ordinary channel data.
               for (int k = 0; k < NUM_CH; k++) begin
                  if (r_ch == CHW'(k + 1)) r_shadow[k] <= w_byte;
               end
               if (r_ch == CHW'(NUM_CH)) begin
                  r_angulos <= w_ang_nx;
                  r_fv      <= 1'b1;
                  r_ch      <= '0;
               end else begin
                  r_ch <= r_ch + CHW'(1);
               end
            end
         end
      end
   end

   assign angulos     = r_angulos;
   assign frame_valid = r_fv;
   assign frame_error = r_fe;
   assign ch_idx      = r_ch;

endmodule
